// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries EX results into MEM and returns the madd/msub
// partial product and cycle counter to EX while EX is stalled.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int STALL_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [STALL_W-1:0]    stall,
  input  logic                  flush,
  input  logic [ADDR_W-1:0]     ex_wd,
  input  logic                  ex_wreg,
  input  logic [DATA_W-1:0]     ex_wdata,
  input  logic                  ex_whilo,
  input  logic [DATA_W-1:0]     ex_hi,
  input  logic [DATA_W-1:0]     ex_lo,
  input  logic [ALUOP_W-1:0]    ex_aluop,
  input  logic [DATA_W-1:0]     ex_mem_addr,
  input  logic [DATA_W-1:0]     ex_reg2,
  input  logic [2*DATA_W-1:0]   hilo_i,
  input  logic [1:0]            cnt_i,
  output logic [ADDR_W-1:0]     mem_wd,
  output logic                  mem_wreg,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_whilo,
  output logic [DATA_W-1:0]     mem_hi,
  output logic [DATA_W-1:0]     mem_lo,
  output logic [ALUOP_W-1:0]    mem_aluop,
  output logic [DATA_W-1:0]     mem_mem_addr,
  output logic [DATA_W-1:0]     mem_reg2,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic [1:0]            cnt_o
);

  localparam int PIPE_W = ADDR_W + 1 + DATA_W + 1 + DATA_W + DATA_W + ALUOP_W + DATA_W + DATA_W;

  // All pipeline fields travel as one vector so bubble/hold/advance treat them uniformly.
  logic [PIPE_W-1:0]   ex_pipe;
  logic [PIPE_W-1:0]   pipe_reg, pipe_next;
  logic [2*DATA_W-1:0] hilo_reg, hilo_next;
  logic [1:0]          cnt_reg, cnt_next;

  // Only the EX (bit 3) and MEM (bit 4) stall bits matter to this stage.
  logic unused_stall_bits;
  assign unused_stall_bits = ^{stall[STALL_W-1:5], stall[2:0]};

  assign ex_pipe = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo,
                    ex_aluop, ex_mem_addr, ex_reg2};

  always_comb begin
    pipe_next = pipe_reg;
    hilo_next = hilo_reg;
    cnt_next  = cnt_reg;
    if (flush) begin
      pipe_next = '0;
      hilo_next = '0;
      cnt_next  = '0;
    end else if (stall[3]) begin
      // EX stalled: MEM gets a NOP unless MEM itself is stalled too.
      if (!stall[4]) begin
        pipe_next = '0;
      end
      hilo_next = hilo_i;
      cnt_next  = cnt_i;
    end else begin
      pipe_next = ex_pipe;
      hilo_next = '0;
      cnt_next  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_reg <= '0;
      hilo_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      pipe_reg <= pipe_next;
      hilo_reg <= hilo_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
          mem_aluop, mem_mem_addr, mem_reg2} = pipe_reg;
  assign hilo_o = hilo_reg;
  assign cnt_o  = cnt_reg;

endmodule

// File: tb/tb_ex_mem.sv
// Bench for ex_mem: directed scenarios plus randomized traffic against a
// behavioural model of the stage's priority rules.
module tb_ex_mem;

  localparam int PW = 175;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_reg2;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr;
  logic [31:0] mem_reg2;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  int errors = 0;
  int checks = 0;

  // Model state: what MEM should be holding, and what EX should be handed back.
  logic [PW-1:0] exp_pipe;
  logic [63:0]   exp_hilo;
  logic [1:0]    exp_cnt;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  function automatic logic [PW-1:0] ex_bundle();
    return {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2};
  endfunction

  function automatic logic [PW-1:0] mem_bundle();
    return {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop, mem_mem_addr, mem_reg2};
  endfunction

  // Apply one clock edge: update the model from the inputs presented, then sample 1ns after.
  task automatic cycle();
    if (!rst) begin
      exp_pipe = '0; exp_hilo = '0; exp_cnt = '0;
    end else if (flush) begin
      exp_pipe = '0; exp_hilo = '0; exp_cnt = '0;
    end else if (stall[3] && !stall[4]) begin
      exp_pipe = '0; exp_hilo = hilo_i; exp_cnt = cnt_i;
    end else if (stall[3]) begin
      exp_hilo = hilo_i; exp_cnt = cnt_i;
    end else begin
      exp_pipe = ex_bundle(); exp_hilo = '0; exp_cnt = '0;
    end
    @(posedge clk);
    #1;
    $display("%0t rst=%b flush=%b stall=%b wd=%0d wreg=%b wdata=%h hilo_o=%h cnt_o=%0d",
             $time, rst, flush, stall, mem_wd, mem_wreg, mem_wdata, hilo_o, cnt_o);
  endtask

  task automatic set_ex(input logic [31:0] seed);
    ex_wd = seed[4:0]; ex_wreg = seed[5]; ex_wdata = seed; ex_whilo = seed[6];
    ex_hi = ~seed; ex_lo = seed ^ 32'h5A5A_5A5A; ex_aluop = seed[15:8];
    ex_mem_addr = seed + 32'd4; ex_reg2 = {seed[15:0], seed[31:16]};
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; stall = 6'b011111;
    ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_whilo = 1'b1; ex_hi = '1; ex_lo = '1;
    ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1; hilo_i = '1; cnt_i = 2'd3;
    cycle();
    cycle();
    checks++;
    if (mem_bundle() !== '0) begin
      errors++; $display("FAIL reset_pipe got=%h want=0", mem_bundle());
    end
    checks++;
    if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
      errors++; $display("FAIL reset_hilo_cnt got=%h/%0d want=0/0", hilo_o, cnt_o);
    end
  endtask

  task automatic test_advance();
    rst = 1'b1; stall = 6'b000000; set_ex(32'h1111_2222);
    ex_wd = 5'd5; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    hilo_i = 64'hDEAD_BEEF_0000_0001; cnt_i = 2'd2;
    cycle();
    checks++;
    if (mem_wd !== 5'd5 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL advance_fields got=%0d/%b/%h want=5/1/12345678", mem_wd, mem_wreg, mem_wdata);
    end
    checks++;
    if (hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
      errors++; $display("FAIL advance_hilo_cnt got=%h/%0d want=0/0", hilo_o, cnt_o);
    end
    checks++;
    if (mem_bundle() !== exp_pipe) begin
      errors++; $display("FAIL advance_all got=%h want=%h", mem_bundle(), exp_pipe);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b001111; set_ex(32'hCAFE_F00D); ex_wreg = 1'b1; ex_wd = 5'd7;
    ex_whilo = 1'b1; ex_aluop = 8'h23;
    hilo_i = 64'h0000_0001_0000_0002; cnt_i = 2'd1;
    cycle();
    checks++;
    if (mem_wreg !== 1'b0 || mem_wd !== 5'd0 || mem_whilo !== 1'b0 || mem_aluop !== 8'd0) begin
      errors++; $display("FAIL bubble_nop got wreg=%b wd=%0d whilo=%b aluop=%h want 0", mem_wreg, mem_wd, mem_whilo, mem_aluop);
    end
    checks++;
    if (hilo_o !== 64'h0000_0001_0000_0002 || cnt_o !== 2'd1) begin
      errors++; $display("FAIL bubble_hilo_cnt got=%h/%0d want=0000000100000002/1", hilo_o, cnt_o);
    end
  endtask

  task automatic test_hold();
    stall = 6'b000000; set_ex(32'h0F0F_0F0F); ex_wdata = 32'hA5A5_A5A5;
    cycle();
    checks++;
    if (mem_wdata !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL hold_load got=%h want=a5a5a5a5", mem_wdata);
    end
    stall = 6'b011111; set_ex(32'h0); ex_wdata = 32'h0;
    hilo_i = 64'h0123_4567_89AB_CDEF; cnt_i = 2'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (mem_wdata !== 32'hA5A5_A5A5 || mem_bundle() !== exp_pipe) begin
        errors++; $display("FAIL hold_edge%0d got=%h want=a5a5a5a5", i, mem_wdata);
      end
      checks++;
      if (hilo_o !== 64'h0123_4567_89AB_CDEF || cnt_o !== 2'd1) begin
        errors++; $display("FAIL hold_hilo%0d got=%h/%0d want=0123456789abcdef/1", i, hilo_o, cnt_o);
      end
    end
  endtask

  task automatic test_flush();
    stall = 6'b011111; flush = 1'b1; hilo_i = 64'h77; cnt_i = 2'd1;
    cycle();
    checks++;
    if (mem_bundle() !== '0 || hilo_o !== 64'd0 || cnt_o !== 2'd0) begin
      errors++; $display("FAIL flush_clear got=%h hilo=%h cnt=%0d want all 0", mem_bundle(), hilo_o, cnt_o);
    end
    flush = 1'b0;
  endtask

  task automatic test_madd();
    logic [PW-1:0] want;
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h10; set_ex(32'h3333_4444);
    cycle();
    checks++;
    if (cnt_o !== 2'd1 || hilo_o !== 64'h10) begin
      errors++; $display("FAIL madd_cycle1 got=%0d/%h want=1/10", cnt_o, hilo_o);
    end
    stall = 6'b000000; cnt_i = 2'd2; hilo_i = 64'h99; set_ex(32'h5555_6666);
    want = ex_bundle();
    cycle();
    checks++;
    if (cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
      errors++; $display("FAIL madd_cycle2 got=%0d/%h want=0/0", cnt_o, hilo_o);
    end
    checks++;
    if (mem_bundle() !== want) begin
      errors++; $display("FAIL madd_fields got=%h want=%h", mem_bundle(), want);
    end
  endtask

  task automatic test_reset_mid_madd();
    logic [PW-1:0] want;
    stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hABCD_0000_1234; set_ex(32'h7777_8888);
    cycle();
    checks++;
    if (cnt_o !== 2'd1) begin
      errors++; $display("FAIL midmadd_start got=%0d want=1", cnt_o);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (cnt_o !== 2'd0 || hilo_o !== 64'd0) begin
      errors++; $display("FAIL midmadd_reset got=%0d/%h want=0/0", cnt_o, hilo_o);
    end
    rst = 1'b1; stall = 6'b100111; set_ex(32'h9999_AAAA);
    want = ex_bundle();
    cycle();
    checks++;
    if (mem_bundle() !== want) begin
      errors++; $display("FAIL post_reset_load got=%h want=%h", mem_bundle(), want);
    end
  endtask

  task automatic test_async_glitch();
    logic [PW-1:0] want;
    stall = 6'b000000; set_ex(32'hBEEF_1234);
    want = ex_bundle();
    cycle();
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    stall = 6'b011111;
    cycle();
    checks++;
    if (mem_bundle() !== want) begin
      errors++; $display("FAIL async_glitch got=%h want=%h", mem_bundle(), want);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      rst    = ($urandom_range(0, 19) != 0);
      flush  = ($urandom_range(0, 11) == 0);
      stall  = 6'($urandom);
      set_ex($urandom);
      hilo_i = {$urandom, $urandom};
      cnt_i  = 2'($urandom);
      cycle();
      checks++;
      if (mem_bundle() !== exp_pipe || hilo_o !== exp_hilo || cnt_o !== exp_cnt) begin
        errors++;
        $display("FAIL random%0d got=%h/%h/%0d want=%h/%h/%0d", i, mem_bundle(), hilo_o, cnt_o, exp_pipe, exp_hilo, exp_cnt);
      end
    end
  endtask

  initial begin
    exp_pipe = '0; exp_hilo = '0; exp_cnt = '0;
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_madd();
    test_reset_mid_madd();
    test_async_glitch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
